// File: rtl/sdr_sym2byte_pkg.sv
// Shared SDR definitions: symbol-size limit, symbol-to-byte FSM states,
// modulation settings record and a small legality helper.
package pkg_sv_sdr;

    // Largest supported bits-per-symbol (QAM4096)
    localparam int SYM_SIZE_MAX = 12;
    // Bit accumulator width and the width of its fill counter
    localparam int ACC_W        = 20;
    localparam int CNT_W        = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DROP  = 2'd2,
        FLUSH = 2'd3
    } t_s2b_state;

    typedef struct packed {
        logic [1:0] mod_type;
        logic [3:0] symbol_size;
    } t_modulation_settings;

    // A symbol size is usable when it is 1..SYM_SIZE_MAX
    function automatic logic size_is_legal(input logic [3:0] size);
        return (size != 4'd0) && (size <= 4'(SYM_SIZE_MAX));
    endfunction

endpackage

// File: rtl/sdr_sym2byte_gray2bin.sv
// Combinational Gray-to-binary decode of a right-justified symbol.
// Bits at or above 'size' are forced to zero before decoding.
module sdr_gray2bin
    import pkg_sv_sdr::*;
#(
    parameter int SYM_W = 12
) (
    input  logic [SYM_W-1:0] gray,
    input  logic [3:0]       size,
    output logic [SYM_W-1:0] bin
);

    logic [SYM_W-1:0] gray_mask_s;

    // Mask to the active symbol width, then prefix-XOR from the MSB down
    always_comb begin
        logic run_v;
        gray_mask_s = '0;
        bin         = '0;
        run_v       = 1'b0;
        for (int i = 0; i < SYM_W; i++) begin
            gray_mask_s[i] = gray[i] & (i < int'(size));
        end
        for (int i = SYM_W - 1; i >= 0; i--) begin
            run_v  = run_v ^ gray_mask_s[i];
            bin[i] = run_v;
        end
    end

endmodule

// File: rtl/sdr_sym2byte.sv
// Symbol-to-byte packer: accumulates isym_size-bit hard-decision symbols
// MSB first and emits BYTE_W-bit words, zero-padding the frame tail.
// Optional build macro SDR_SYM2BYTE_GRAY_EN: Gray-decode each symbol
// (via sdr_gray2bin) before packing.
module sdr_sym2byte
    import pkg_sv_sdr::*;
#(
    parameter int SYM_W  = 12,
    parameter int BYTE_W = 8
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic [3:0]        isym_size,
    input  logic              i_valid,
    input  logic [SYM_W-1:0]  i_data,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_valid,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_err
);

    localparam logic [CNT_W-1:0] BYTE_CNT = CNT_W'(BYTE_W);
    localparam logic [CNT_W-1:0] ACC_CNT  = CNT_W'(ACC_W);

    t_s2b_state         state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;
    logic [ACC_W-1:0]   acc_r, acc_next_s;
    logic [3:0]         size_r, size_eff_s;
    logic [SYM_W-1:0]   sym_mask_s, sym_app_s;
    logic [ACC_W-1:0]   sym_ext_s;
    logic [CNT_W-1:0]   shift_s;
    logic               o_ready_s, in_xfer_s, start_s, illegal_s, append_s;
    logic               out_free_s, emit_s, last_s;
    logic               o_valid_r, o_last_r, o_err_r;
    logic [BYTE_W-1:0]  o_data_r;

    // Transfer qualifiers, effective symbol size and byte-emit decision
    always_comb begin
        in_xfer_s  = i_valid && o_ready_s;
        start_s    = in_xfer_s && (state_r == IDLE);
        size_eff_s = (state_r == IDLE) ? isym_size : size_r;
        illegal_s  = start_s && !size_is_legal(isym_size);
        if (state_r == IDLE) begin
            append_s = start_s && size_is_legal(isym_size);
        end else begin
            append_s = in_xfer_s && (state_r == RUN);
        end
        out_free_s = !o_valid_r || i_ready;
        emit_s     = out_free_s && ((cnt_r >= BYTE_CNT) ||
                                    ((state_r == FLUSH) && (cnt_r != '0)));
        last_s     = (state_r == FLUSH) && (cnt_r <= BYTE_CNT);
    end

    // Drop the bits above the active symbol width
    always_comb begin
        sym_mask_s = '0;
        for (int i = 0; i < SYM_W; i++) begin
            sym_mask_s[i] = i_data[i] & (i < int'(size_eff_s));
        end
    end

`ifdef SDR_SYM2BYTE_GRAY_EN
    sdr_gray2bin #(
        .SYM_W (SYM_W)
    ) u_gray2bin (
        .gray (sym_mask_s),
        .size (size_eff_s),
        .bin  (sym_app_s)
    );
`else
    assign sym_app_s = sym_mask_s;
`endif

    // Next accumulator contents: either shift out a byte or append a symbol
    // (the two never coincide because o_ready requires cnt < BYTE_W)
    always_comb begin
        sym_ext_s  = {{(ACC_W-SYM_W){1'b0}}, sym_app_s};
        shift_s    = ACC_CNT - cnt_r - {1'b0, size_eff_s};
        acc_next_s = acc_r;
        cnt_next_s = cnt_r;
        if (emit_s) begin
            acc_next_s = acc_r << BYTE_W;
            cnt_next_s = (cnt_r >= BYTE_CNT) ? (cnt_r - BYTE_CNT) : '0;
        end else if (append_s) begin
            acc_next_s = acc_r | (sym_ext_s << shift_s);
            cnt_next_s = cnt_r + {1'b0, size_eff_s};
        end else begin
            acc_next_s = acc_r;
            cnt_next_s = cnt_r;
        end
    end

    // FSM state register
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    if (illegal_s) begin
                        state_next_s = i_last ? IDLE : DROP;
                    end else begin
                        state_next_s = i_last ? FLUSH : RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (in_xfer_s && i_last) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = RUN;
                end
            end
            DROP: begin
                if (in_xfer_s && i_last) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DROP;
                end
            end
            FLUSH: begin
                if ((cnt_r == '0) && out_free_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FLUSH;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: upstream may transfer only while a whole symbol fits
    always_comb begin
        o_ready_s = !ireset && (state_r != FLUSH) && (cnt_r < BYTE_CNT);
    end

    // Accumulator, fill count, latched frame size and registered outputs
    always_ff @(posedge iclk) begin
        if (ireset) begin
            acc_r     <= '0;
            cnt_r     <= '0;
            size_r    <= 4'd0;
            o_valid_r <= 1'b0;
            o_data_r  <= '0;
            o_last_r  <= 1'b0;
            o_err_r   <= 1'b0;
        end else begin
            acc_r   <= acc_next_s;
            cnt_r   <= cnt_next_s;
            o_err_r <= illegal_s;
            if (start_s) begin
                size_r <= isym_size;
            end else begin
                size_r <= size_r;
            end
            if (emit_s) begin
                o_valid_r <= 1'b1;
                o_data_r  <= acc_r[ACC_W-1 -: BYTE_W];
                o_last_r  <= last_s;
            end else if (i_ready) begin
                o_valid_r <= 1'b0;
                o_last_r  <= 1'b0;
            end else begin
                o_valid_r <= o_valid_r;
                o_last_r  <= o_last_r;
            end
        end
    end

    assign o_ready = o_ready_s;
    assign o_valid = o_valid_r;
    assign o_data  = o_data_r;
    assign o_last  = o_last_r;
    assign o_err   = o_err_r;

endmodule
